// File: rtl/moore_1010_overlap_detector.sv
// moore_1010_overlap_detector
//   Serial 1-0-1-0 sequence detector (Moore FSM, overlapping matches allowed).
//   The detect flag is a registered copy of "state is S1010", so it never
//   depends combinationally on the serial input.
//
// Ports
//   clk      : rising-edge clock
//   rst      : asynchronous, active-low reset
//   in       : serial data bit, sampled on each rising clk edge
//   out      : detect flag, high for the one cycle spent in S1010
//   det_cnt  : saturating detection count since reset
//              (present only when MOORE1010_DET_COUNT_EN is defined)
//
// Parameters
//   CNT_W    : detection counter width, 1..32
//
// Build option
//   MOORE1010_DET_COUNT_EN : compiles in det_cnt and its counter logic.

module moore_1010_overlap_detector #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in,
`ifdef MOORE1010_DET_COUNT_EN
  output logic [CNT_W-1:0] det_cnt,
`endif
  output logic             out
);

  // Reject illegal counter widths at elaboration time.
  if ((CNT_W < 1) || (CNT_W > 32)) begin : g_cnt_w_check
    $error("moore_1010_overlap_detector: CNT_W must be in 1..32");
  end

  typedef enum logic [2:0] {
    S0    = 3'd0,
    S1    = 3'd1,
    S10   = 3'd2,
    S101  = 3'd3,
    S1010 = 3'd4
  } state_e;

  state_e state_q;
  state_e state_d;

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S0;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; unused encodings fall back to S0.
  always_comb begin
    state_d = S0;
    case (state_q)
      S0:      state_d = in ? S1   : S0;
      S1:      state_d = in ? S1   : S10;
      S10:     state_d = in ? S101 : S0;
      S101:    state_d = in ? S1   : S1010;
      // Trailing "10" of a match is reused as the prefix of the next one.
      S1010:   state_d = in ? S101 : S0;
      default: state_d = S0;
    endcase
  end

  // Detect flag registered alongside the state so it equals (state_q == S1010).
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out <= 1'b0;
    end else begin
      out <= (state_d == S1010);
    end
  end

`ifdef MOORE1010_DET_COUNT_EN
  localparam logic [CNT_W-1:0] CntMax = {CNT_W{1'b1}};

  // Saturating detection counter, updated on the same edge that raises out.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      det_cnt <= '0;
    end else if ((state_d == S1010) && (det_cnt != CntMax)) begin
      det_cnt <= det_cnt + CNT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_moore_1010_overlap_detector.sv
module tb_moore_1010_overlap_detector;

  localparam int unsigned CNT_W = 2;

  logic clk;
  logic rst;
  logic in;
  logic out;
`ifdef MOORE1010_DET_COUNT_EN
  logic [CNT_W-1:0] det_cnt;
`endif

  int compared   = 0;
  int mismatched = 0;

`ifdef MOORE1010_DET_COUNT_EN
  moore_1010_overlap_detector #(.CNT_W(CNT_W)) dut (
    .clk     (clk),
    .rst     (rst),
    .in      (in),
    .det_cnt (det_cnt),
    .out     (out)
  );
`else
  moore_1010_overlap_detector #(.CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .in  (in),
    .out (out)
  );
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_det(input string tag, input int exp);
`ifdef MOORE1010_DET_COUNT_EN
    check(tag, int'(det_cnt), exp);
`endif
  endtask

  // Entered at a falling edge: drive the bit, let one rising edge sample it,
  // check the outputs 1 time unit later, then return at the next falling edge.
  task automatic step(input string tag, input logic b, input logic exp_out, input int exp_det);
    in = b;
    @(posedge clk);
    #1;
    check({tag, ".out"}, int'(out), int'(exp_out));
    check_det({tag, ".cnt"}, exp_det);
    @(negedge clk);
  endtask

  // Entered at a falling edge: pulse reset for one cycle, release at a falling edge.
  task automatic do_reset();
    rst = 1'b0;
    #1;
    check("rst.out", int'(out), 0);
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    rst = 1'b0;
    in  = 1'b0;
    @(negedge clk);

    // Reset held for two cycles with the input toggling.
    in = 1'b1;
    @(posedge clk); #1;
    check("hold0.out", int'(out), 0);
    check_det("hold0.cnt", 0);
    @(negedge clk);
    in = 1'b0;
    @(posedge clk); #1;
    check("hold1.out", int'(out), 0);
    check_det("hold1.cnt", 0);
    @(negedge clk);
    rst = 1'b1;

    // Overlap stream 1,0,1,0,1,0,1,0,1: pulses after bits 4, 6, 8.
    step("ovl1", 1'b1, 1'b0, 0);
    step("ovl2", 1'b0, 1'b0, 0);
    step("ovl3", 1'b1, 1'b0, 0);
    step("ovl4", 1'b0, 1'b1, 1);
    step("ovl5", 1'b1, 1'b0, 1);
    step("ovl6", 1'b0, 1'b1, 2);
    step("ovl7", 1'b1, 1'b0, 2);
    step("ovl8", 1'b0, 1'b1, 3);
    step("ovl9", 1'b1, 1'b0, 3);

    // Non-overlap break 1,0,1,0,0,1,0,1,0: pulses after bits 4 and 9.
    do_reset();
    step("brk1", 1'b1, 1'b0, 0);
    step("brk2", 1'b0, 1'b0, 0);
    step("brk3", 1'b1, 1'b0, 0);
    step("brk4", 1'b0, 1'b1, 1);
    step("brk5", 1'b0, 1'b0, 1);
    step("brk6", 1'b1, 1'b0, 1);
    step("brk7", 1'b0, 1'b0, 1);
    step("brk8", 1'b1, 1'b0, 1);
    step("brk9", 1'b0, 1'b1, 2);

    // Near misses 1,1,0,1,1,0,0,1,0: S101->S1 and S10->S0 paths, no pulse.
    do_reset();
    step("nm1", 1'b1, 1'b0, 0);
    step("nm2", 1'b1, 1'b0, 0);
    step("nm3", 1'b0, 1'b0, 0);
    step("nm4", 1'b1, 1'b0, 0);
    step("nm5", 1'b1, 1'b0, 0);
    step("nm6", 1'b0, 1'b0, 0);
    step("nm7", 1'b0, 1'b0, 0);
    step("nm8", 1'b1, 1'b0, 0);
    step("nm9", 1'b0, 1'b0, 0);

    // Asynchronous reset while out is high.
    do_reset();
    step("ar1", 1'b1, 1'b0, 0);
    step("ar2", 1'b0, 1'b0, 0);
    step("ar3", 1'b1, 1'b0, 0);
    in = 1'b0;
    @(posedge clk); #1;
    check("ar4.out", int'(out), 1);
    check_det("ar4.cnt", 1);
    #2;
    rst = 1'b0;
    #1;
    check("ar_async.out", int'(out), 0);
    check_det("ar_async.cnt", 0);
    @(negedge clk);
    in = 1'b1;
    @(posedge clk); #1;
    check("ar_held.out", int'(out), 0);
    @(negedge clk);
    rst = 1'b1;
    // Partial 0,1,0 does not fire; a fresh 1,0,1,0 does.
    step("arp1", 1'b0, 1'b0, 0);
    step("arp2", 1'b1, 1'b0, 0);
    step("arp3", 1'b0, 1'b0, 0);
    step("arp4", 1'b0, 1'b0, 0);
    step("arf1", 1'b1, 1'b0, 0);
    step("arf2", 1'b0, 1'b0, 0);
    step("arf3", 1'b1, 1'b0, 0);
    step("arf4", 1'b0, 1'b1, 1);
    step("arf5", 1'b0, 1'b0, 1);

    // Five overlapping detections: counter saturates at 3 with CNT_W=2.
    do_reset();
    step("sat1",  1'b1, 1'b0, 0);
    step("sat2",  1'b0, 1'b0, 0);
    step("sat3",  1'b1, 1'b0, 0);
    step("sat4",  1'b0, 1'b1, 1);
    step("sat5",  1'b1, 1'b0, 1);
    step("sat6",  1'b0, 1'b1, 2);
    step("sat7",  1'b1, 1'b0, 2);
    step("sat8",  1'b0, 1'b1, 3);
    step("sat9",  1'b1, 1'b0, 3);
    step("sat10", 1'b0, 1'b1, 3);
    step("sat11", 1'b1, 1'b0, 3);
    step("sat12", 1'b0, 1'b1, 3);
    step("sat13", 1'b0, 1'b0, 3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/moore_1010_overlap_detector.md
Name:
moore_1010_overlap_detector

Overview:
- Single-bit serial sequence detector for the pattern 1-0-1-0, with overlapping detections allowed.
- Implemented as a Moore FSM: the output is decoded from the state register only.
- Sits on a serial bit stream sampled once per clock. It raises a one-cycle flag each time the last four sampled bits equal 1010.
- An optional saturating detection counter can be compiled in for debug and statistics.

Parameters:
- CNT_W, default 8: width of the optional detection counter (legal range 1..32).

Ports:
- clk, input, 1: rising-edge clock.
- rst, input, 1: asynchronous, active-low reset.
- in, input, 1: serial data bit, sampled on each rising clk edge.
- out, output, 1: detect flag; high for exactly the cycle while the FSM is in S1010.
- det_cnt, output, CNT_W: number of detections since reset; saturating. Present only with MOORE1010_DET_COUNT_EN defined.

Behaviour:
- One clock; reset is asynchronous and active-low.
- rst low (any time, independent of clk):
  - state = S0
  - out = 0
  - det_cnt = 0
- States and their out value:
  - S0 (idle), out=0
  - S1 (seen 1), out=0
  - S10, out=0
  - S101, out=0
  - S1010 (detected), out=1
  - Encoding is free; unused encodings must recover to S0 on the next clock.
- Transitions, evaluated on each rising clk edge while rst is high (in=0 / in=1):
  - S0: 0 -> S0, 1 -> S1
  - S1: 0 -> S10, 1 -> S1
  - S10: 0 -> S0, 1 -> S101
  - S101: 0 -> S1010, 1 -> S1
  - S1010: 0 -> S0, 1 -> S101 (overlap: the trailing "10" is reused as a prefix)
- Latency:
  - out rises at the clk edge that samples the final 0 of 1010.
  - out stays high for exactly one cycle, unless the next sampled bits 1,0 create a new detection two cycles later.
- out is driven directly from the state register. There is no combinational path from in to out.
- Minimum spacing between detections is 2 cycles (stream 1010 10 10 ...). out can never be high on two consecutive cycles.
- Reset released mid-stream: detection restarts from S0. Bits sampled before or during reset are not counted.
- Reset asserted while in S1010: out drops to 0 immediately (asynchronously).
- The first rising edge after rst deasserts samples in normally; no dead cycle.

Optional Feature:
- Macro: MOORE1010_DET_COUNT_EN.
- Defined:
  - det_cnt port exists.
  - det_cnt increments by 1 on every clk edge at which the next state is S1010, so it updates in the same cycle out rises.
  - det_cnt saturates at 2^CNT_W-1 and never wraps.
  - det_cnt clears asynchronously with rst.
- Not defined:
  - det_cnt port and all counter logic are absent.
  - FSM and out behaviour are identical in both builds.

Test Plan:
- Reset: hold rst=0 for 2 cycles with in toggling -> out=0 and det_cnt=0 throughout. Release rst; the first edge samples in.
- Overlap stream: after reset, in = 1,0,1,0,1,0,1,0,1, one bit per cycle.
  - out high for one cycle after bit 4, bit 6 and bit 8 (three pulses).
  - out=0 after bit 9.
  - det_cnt=3.
- Non-overlap break: in = 1,0,1,0,0,1,0,1,0 -> out pulses after bit 4 and after bit 9 only; det_cnt=2.
- Near misses: in = 1,1,0,1,1,0,0,1,0 -> out never high; verify the S101 -> S1 (1 after 101) and S10 -> S0 (0 after 10) paths.
- Async reset mid-detect: assert rst=0 mid-cycle while out=1 -> out=0 immediately, before the next clk edge. After release, in = 0,1,0 alone does not trigger; a full 1,0,1,0 is required.
- Saturation: with CNT_W=2 and macro defined, apply 5 overlapping detections -> det_cnt reads 1, 2, 3, 3, 3.
